// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped I/O block.
package mmio_pkg;

   // Register map (exact 9-bit match; mem_addr[8]=1 selects I/O space)
   localparam logic [8:0] ADDR_LED    = 9'h100;
   localparam logic [8:0] ADDR_SW     = 9'h140;
   localparam logic [8:0] ADDR_TIMER  = 9'h180;
   localparam logic [8:0] ADDR_KEYEVT = 9'h1C0;

   // Bus command encodings (2'b11 also means no operation)
   localparam logic [1:0] MEM_WRITE = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_NONE  = 2'b10;

   // Per-key debounce states: released, checking a press, held, checking a release
   typedef enum logic [1:0] {
      IDLE_UP = 2'd0,
      CHK_DN  = 2'd1,
      HELD_DN = 2'd2,
      CHK_UP  = 2'd3
   } key_state_t;

endpackage

// File: rtl/mmio_peripheral_key_debounce.sv
// One push-button path: 2-flop synchronizer, debounce FSM and stability counter.
// o_press is a one-cycle registered pulse raised when a press is accepted.
module key_debounce
   import mmio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
)
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_key_n,
   output logic       o_press,
   output key_state_t o_state
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    r_sync;
   key_state_t    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_press;
   logic          w_sample;
   logic          w_last;

   assign w_sample = r_sync[1];
   // The sample now being taken is the DEBOUNCE_CYCLES-th consecutive one
   assign w_last   = (r_cnt == CNT_LAST);
   assign o_press  = r_press;
   assign o_state  = r_state;

   // Synchronizer resets to 1 so a released key reads as released
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_sync <= 2'b11;
      else          r_sync <= {r_sync[0], i_key_n};
   end

   // Debounce FSM: count consecutive samples at the opposite level before switching
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE_UP;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_press <= 1'b0;
         case (r_state)
            IDLE_UP: begin
               if (!w_sample) begin
                  if (w_last) begin
                     r_state <= HELD_DN;
                     r_press <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_state <= CHK_DN;
                     r_cnt   <= r_cnt + 1'b1;
                  end
               end
            end
            CHK_DN: begin
               if (w_sample) begin
                  r_state <= IDLE_UP;
                  r_cnt   <= '0;
               end else if (w_last) begin
                  r_state <= HELD_DN;
                  r_press <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            HELD_DN: begin
               if (w_sample) begin
                  if (w_last) begin
                     r_state <= IDLE_UP;
                     r_cnt   <= '0;
                  end else begin
                     r_state <= CHK_UP;
                     r_cnt   <= r_cnt + 1'b1;
                  end
               end
            end
            CHK_UP: begin
               if (!w_sample) begin
                  r_state <= HELD_DN;
                  r_cnt   <= '0;
               end else if (w_last) begin
                  r_state <= IDLE_UP;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE_UP;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mmio_peripheral.sv
// Memory-mapped I/O unit: LED register, synchronized switches, prescaled
// 16-bit timer and sticky debounced key-press flags.
// Bus protocol: no handshake. A read (mem_cmd=01) is answered combinationally
// in the same cycle with read_hit high on a map match; a write (mem_cmd=00)
// commits on the rising clk edge while it is presented. Reads have no side effects.
module mmio_peripheral
   import mmio_pkg::*;
#(
   parameter int TICK_DIV        = 50000,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int NKEY            = 2
)
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic [1:0]      mem_cmd,
   input  logic [8:0]      mem_addr,
   input  logic [15:0]     write_data,
   input  logic [7:0]      sw_in,
   input  logic [NKEY-1:0] key_in,
   output logic [15:0]     read_data,
   output logic            read_hit,
   output logic [7:0]      ledr
);

   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [7:0]      r_led;
   logic [7:0]      r_sw_meta;
   logic [7:0]      r_sw_sync;
   logic [PW-1:0]   r_presc;
   logic [15:0]     r_count;
   logic [NKEY-1:0] r_key_flags;

   logic            w_wr;
   logic            w_rd;
   logic [NKEY-1:0] w_key_press;
   logic [NKEY-1:0] w_evt_clr;
   key_state_t      w_unused_key_state [NKEY];

   assign w_wr      = (mem_cmd == MEM_WRITE);
   assign w_rd      = (mem_cmd == MEM_READ);
   assign w_evt_clr = (w_wr && mem_addr == ADDR_KEYEVT) ? write_data[NKEY-1:0] : '0;
   assign ledr      = r_led;

   // LED register, written only through its own address
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         r_led <= '0;
      else if (w_wr && mem_addr == ADDR_LED) r_led <= write_data[7:0];
   end

   // Two-flop switch synchronizer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sw_meta <= '0;
         r_sw_sync <= '0;
      end else begin
         r_sw_meta <= sw_in;
         r_sw_sync <= r_sw_meta;
      end
   end

   // Prescaled timer; a CPU load overrides a coincident tick and restarts the prescaler
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc <= '0;
         r_count <= '0;
      end else if (w_wr && mem_addr == ADDR_TIMER) begin
         r_presc <= '0;
         r_count <= write_data;
      end else if (r_presc == PRESC_LAST) begin
         r_presc <= '0;
         r_count <= r_count + 16'd1;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   // One debounce path per key
   genvar gi;
   generate
      for (gi = 0; gi < NKEY; gi++) begin : g_key
         key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_key (
            .clk     (clk),
            .reset_n (reset_n),
            .i_key_n (key_in[gi]),
            .o_press (w_key_press[gi]),
            .o_state (w_unused_key_state[gi])
         );
      end
   endgenerate

   // Sticky event flags: write-1-to-clear, a new press on the same edge wins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_key_flags <= '0;
      else          r_key_flags <= (r_key_flags & ~w_evt_clr) | w_key_press;
   end

   // Combinational read decode from registered state
   always_comb begin
      read_hit  = 1'b0;
      read_data = 16'h0000;
      if (w_rd) begin
         case (mem_addr)
            ADDR_LED: begin
               read_hit  = 1'b1;
               read_data = {8'h00, r_led};
            end
            ADDR_SW: begin
               read_hit  = 1'b1;
               read_data = {8'h00, r_sw_sync};
            end
            ADDR_TIMER: begin
               read_hit  = 1'b1;
               read_data = r_count;
            end
            ADDR_KEYEVT: begin
               read_hit  = 1'b1;
               read_data = 16'(r_key_flags);
            end
            default: begin
               read_hit  = 1'b0;
               read_data = 16'h0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_peripheral.sv
// Self-checking bench for mmio_peripheral with a behavioural reference model.
module tb_mmio_peripheral;
   import mmio_pkg::*;

   localparam int TICK_DIV = 4;
   localparam int DEB      = 16;
   localparam int NKEY     = 2;

   // ---------------- clock / reset ----------------
   logic            clk = 1'b0;
   logic            reset_n;
   logic [1:0]      mem_cmd;
   logic [8:0]      mem_addr;
   logic [15:0]     write_data;
   logic [7:0]      sw_in;
   logic [NKEY-1:0] key_in;
   logic [15:0]     read_data;
   logic            read_hit;
   logic [7:0]      ledr;

   always #5 clk = ~clk;

   mmio_peripheral #(
      .TICK_DIV       (TICK_DIV),
      .DEBOUNCE_CYCLES(DEB),
      .NKEY           (NKEY)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .mem_cmd   (mem_cmd),
      .mem_addr  (mem_addr),
      .write_data(write_data),
      .sw_in     (sw_in),
      .key_in    (key_in),
      .read_data (read_data),
      .read_hit  (read_hit),
      .ledr      (ledr)
   );

   // ---------------- scoreboard counters / check ----------------
   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Timer value is the last loaded value plus whole TICK_DIV periods since then.
   // Keys: each sampled level reaches the debouncer two edges later; the
   // debounced level flips after DEB consecutive opposite samples, and an
   // accepted press lands in the flag register one edge after that.
   logic [7:0]      m_led;
   logic [7:0]      m_sw_d1, m_sw_d2;
   logic [15:0]     m_load;
   int              m_since;
   logic [NKEY-1:0] m_key_d1, m_key_d2, m_level, m_flags, m_press_pend;
   int              m_run [NKEY];

   function automatic void model_reset();
      m_led        = '0;
      m_sw_d1      = '0;
      m_sw_d2      = '0;
      m_load       = '0;
      m_since      = 0;
      m_key_d1     = '1;
      m_key_d2     = '1;
      m_level      = '1;
      m_flags      = '0;
      m_press_pend = '0;
      for (int k = 0; k < NKEY; k++) m_run[k] = 0;
   endfunction

   function automatic logic [15:0] m_timer();
      return m_load + 16'(m_since / TICK_DIV);
   endfunction

   function automatic logic [16:0] model_read(input logic [1:0] cmd, input logic [8:0] addr);
      if (cmd != 2'b01) return 17'h0;
      case (addr)
         9'h100:  return {1'b1, 8'h00, m_led};
         9'h140:  return {1'b1, 8'h00, m_sw_d2};
         9'h180:  return {1'b1, m_timer()};
         9'h1C0:  return {1'b1, 16'(m_flags)};
         default: return 17'h0;
      endcase
   endfunction

   function automatic void model_edge();
      logic [NKEY-1:0] clr;
      logic [NKEY-1:0] fsm_in;
      logic            wr;
      wr = (mem_cmd == 2'b00);
      if (wr && mem_addr == 9'h100) m_led = write_data[7:0];
      m_sw_d2 = m_sw_d1;
      m_sw_d1 = sw_in;
      if (wr && mem_addr == 9'h180) begin
         m_load  = write_data;
         m_since = 0;
      end else begin
         m_since++;
      end
      clr     = (wr && mem_addr == 9'h1C0) ? write_data[NKEY-1:0] : '0;
      m_flags = (m_flags & ~clr) | m_press_pend;
      fsm_in   = m_key_d2;
      m_key_d2 = m_key_d1;
      m_key_d1 = key_in;
      m_press_pend = '0;
      for (int k = 0; k < NKEY; k++) begin
         if (fsm_in[k] != m_level[k]) begin
            m_run[k]++;
            if (m_run[k] == DEB) begin
               m_level[k] = fsm_in[k];
               m_run[k]   = 0;
               if (!m_level[k]) m_press_pend[k] = 1'b1;
            end
         end else begin
            m_run[k] = 0;
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   // One clock: present a bus command, advance model with the edge, then check outputs
   task automatic cycle(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
      logic [16:0] e;
      mem_cmd    = cmd;
      mem_addr   = addr;
      write_data = wd;
      @(posedge clk);
      model_edge();
      #1;
      e = model_read(mem_cmd, mem_addr);
      check_val("ledr", 16'(ledr), 16'(m_led));
      check_val("hit", 16'(read_hit), 16'(e[16]));
      check_val("rdata", read_data, e[15:0]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(MEM_NONE, 9'h000, 16'h0000);
   endtask

   // Combinational probe between edges against a fixed expected value
   task automatic probe(input string tag, input logic [1:0] cmd, input logic [8:0] addr,
                        input logic exp_hit, input logic [15:0] exp_data);
      mem_cmd  = cmd;
      mem_addr = addr;
      #1;
      check_val({tag, "_hit"}, 16'(read_hit), 16'(exp_hit));
      check_val({tag, "_data"}, read_data, exp_data);
   endtask

   task automatic apply_reset(input int n, input logic [NKEY-1:0] key_after);
      reset_n = 1'b0;
      model_reset();
      for (int i = 0; i < n; i++) begin
         mem_cmd    = 2'($urandom);
         mem_addr   = 9'($urandom);
         write_data = 16'($urandom);
         sw_in      = 8'($urandom);
         key_in     = NKEY'($urandom);
         @(posedge clk);
         #1;
         check_val("rst_ledr", 16'(ledr), 16'h0000);
      end
      mem_cmd    = MEM_NONE;
      mem_addr   = 9'h000;
      write_data = 16'h0000;
      sw_in      = 8'h00;
      key_in     = key_after;
      reset_n    = 1'b1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic race_seen;
      reset_n    = 1'b0;
      mem_cmd    = MEM_NONE;
      mem_addr   = 9'h000;
      write_data = 16'h0000;
      sw_in      = 8'h00;
      key_in     = '1;
      @(posedge clk);
      #1;

      // Reset values
      apply_reset(4, '1);
      check_val("reset_ledr", 16'(ledr), 16'h0000);
      probe("reset_timer", MEM_READ, 9'h180, 1'b1, 16'h0000);
      probe("reset_keyevt", MEM_READ, 9'h1C0, 1'b1, 16'h0000);
      probe("reset_unmapped", MEM_READ, 9'h0FF, 1'b0, 16'h0000);
      probe("reset_cmd10", 2'b10, 9'h100, 1'b0, 16'h0000);

      // LED and switches
      cycle(MEM_WRITE, 9'h100, 16'hABCD);
      check_val("led_cd", 16'(ledr), 16'h00CD);
      probe("led_read", MEM_READ, 9'h100, 1'b1, 16'h00CD);
      sw_in = 8'h5A;
      cycle(MEM_READ, 9'h140, 16'h0000);
      probe("sw_edge1", MEM_READ, 9'h140, 1'b1, 16'h0000);
      cycle(MEM_READ, 9'h140, 16'h0000);
      probe("sw_edge2", MEM_READ, 9'h140, 1'b1, 16'h005A);
      cycle(MEM_READ, 9'h140, 16'h0000);
      cycle(MEM_WRITE, 9'h140, 16'hFFFF);
      check_val("sw_write_led", 16'(ledr), 16'h00CD);
      probe("sw_write_ro", MEM_READ, 9'h140, 1'b1, 16'h005A);

      // Timer
      apply_reset(2, '1);
      idle(4);
      probe("timer_4", MEM_READ, 9'h180, 1'b1, 16'h0001);
      idle(4);
      probe("timer_8", MEM_READ, 9'h180, 1'b1, 16'h0002);
      cycle(MEM_WRITE, 9'h180, 16'hFFFF);
      idle(4);
      probe("timer_wrap", MEM_READ, 9'h180, 1'b1, 16'h0000);
      for (int i = 0; i < TICK_DIV && (m_since % TICK_DIV) != TICK_DIV - 1; i++) idle(1);
      cycle(MEM_WRITE, 9'h180, 16'h1234);
      probe("timer_tick_write", MEM_READ, 9'h180, 1'b1, 16'h1234);
      idle(3);
      probe("timer_after_load3", MEM_READ, 9'h180, 1'b1, 16'h1234);
      idle(1);
      probe("timer_after_load4", MEM_READ, 9'h180, 1'b1, 16'h1235);

      // Debounce: short press rejected
      key_in[0] = 1'b0;
      for (int i = 0; i < 10; i++) cycle(MEM_READ, 9'h1C0, 16'h0000);
      key_in[0] = 1'b1;
      for (int i = 0; i < 25; i++) cycle(MEM_READ, 9'h1C0, 16'h0000);
      probe("short_press", MEM_READ, 9'h1C0, 1'b1, 16'h0000);

      // Debounce: long press accepted, bouncing release sets nothing
      key_in[0] = 1'b0;
      for (int i = 0; i < 20; i++) cycle(MEM_READ, 9'h1C0, 16'h0000);
      for (int i = 0; i < 12; i++) begin
         key_in[0] = 1'($urandom);
         cycle(MEM_READ, 9'h1C0, 16'h0000);
      end
      key_in[0] = 1'b1;
      for (int i = 0; i < 25; i++) cycle(MEM_READ, 9'h1C0, 16'h0000);
      probe("long_press", MEM_READ, 9'h1C0, 1'b1, 16'h0001);

      // Clear of flag 0 on the same edge key 1 qualifies
      race_seen = 1'b0;
      key_in[1] = 1'b0;
      for (int i = 0; i < 40 && !race_seen; i++) begin
         if (m_press_pend[1]) begin
            cycle(MEM_WRITE, 9'h1C0, 16'h0001);
            race_seen = 1'b1;
         end else begin
            cycle(MEM_READ, 9'h1C0, 16'h0000);
         end
      end
      check_val("race_seen", 16'(race_seen), 16'h0001);
      probe("race_result", MEM_READ, 9'h1C0, 1'b1, 16'h0002);
      key_in[1] = 1'b1;
      for (int i = 0; i < 25; i++) cycle(MEM_READ, 9'h1C0, 16'h0000);
      cycle(MEM_WRITE, 9'h1C0, 16'h0002);
      probe("clear_key1", MEM_READ, 9'h1C0, 1'b1, 16'h0000);

      // Reset in the middle of a press: count restarts after release of reset
      key_in[0] = 1'b0;
      for (int i = 0; i < 8; i++) cycle(MEM_READ, 9'h1C0, 16'h0000);
      apply_reset(2, 2'b10);
      probe("midrst_start", MEM_READ, 9'h1C0, 1'b1, 16'h0000);
      for (int i = 0; i < 18; i++) cycle(MEM_READ, 9'h1C0, 16'h0000);
      probe("midrst_18", MEM_READ, 9'h1C0, 1'b1, 16'h0000);
      cycle(MEM_READ, 9'h1C0, 16'h0000);
      probe("midrst_19", MEM_READ, 9'h1C0, 1'b1, 16'h0001);
      key_in[0] = 1'b1;
      for (int i = 0; i < 25; i++) cycle(MEM_READ, 9'h1C0, 16'h0000);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [8:0] a;
         case ($urandom_range(0, 4))
            0:       a = 9'h100;
            1:       a = 9'h140;
            2:       a = 9'h180;
            3:       a = 9'h1C0;
            default: a = 9'($urandom);
         endcase
         if ($urandom_range(0, 15) == 0) sw_in = 8'($urandom);
         for (int k = 0; k < NKEY; k++) begin
            if ($urandom_range(0, 29) == 0) key_in[k] = ~key_in[k];
         end
         cycle(2'($urandom), a, 16'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
